// File: rtl/car_sensor_driver.sv
// car_sensor_driver: replays the two-sensor blocking pattern of a car passing
// the parking-lot gate (enter or exit), holding each phase for h_eff cycles.
//
// Handshake: start_enter/start_exit are single-cycle requests with no ready
// signal. A request is taken only in IDLE and only when exactly one start is
// high. Every other start (both high in IDLE, or any start while busy) is
// refused and answered by a one-cycle rejected pulse in the following cycle.
module car_sensor_driver #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_enter,
  input  logic              start_exit,
  input  logic [HOLD_W-1:0] hold,
  output logic              outer,
  output logic              inner,
  output logic              busy,
  output logic              done,
  output logic              rejected,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [HOLD_W-1:0] ONE = HOLD_W'(1);

  state_t            state, state_nx;
  logic              dir, dir_nx;          // 0 = enter, 1 = exit
  logic [HOLD_W-1:0] cnt, cnt_nx;
  logic [HOLD_W-1:0] h_eff, h_eff_nx;
  logic [HOLD_W-1:0] hold_eff;
  logic              outer_nx, inner_nx, busy_nx, done_nx, rejected_nx;

  // A hold of zero behaves like one so each phase is visible for a cycle.
  assign hold_eff  = (hold == '0) ? ONE : hold;
  assign dbg_state = state;

  // State, counter and all outputs are registered so the sensors never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= 1'b0;
      cnt      <= '0;
      h_eff    <= '0;
      outer    <= 1'b0;
      inner    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      cnt      <= cnt_nx;
      h_eff    <= h_eff_nx;
      outer    <= outer_nx;
      inner    <= inner_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      rejected <= rejected_nx;
    end
  end

  // Next-state, phase counting, request arbitration and sensor decode.
  always_comb begin
    state_nx    = state;
    dir_nx      = dir;
    cnt_nx      = cnt;
    h_eff_nx    = h_eff;
    done_nx     = 1'b0;
    rejected_nx = 1'b0;
    outer_nx    = 1'b0;
    inner_nx    = 1'b0;

    if (state == IDLE) begin
      if (start_enter ^ start_exit) begin
        dir_nx   = start_exit;
        h_eff_nx = hold_eff;
        cnt_nx   = hold_eff - ONE;
        state_nx = PH1;
      end else if (start_enter && start_exit) begin
        rejected_nx = 1'b1;
      end
    end else begin
      if (start_enter || start_exit) begin
        rejected_nx = 1'b1;
      end
      if (cnt == '0) begin
        // Reload with h_eff-1 so the count never wraps, even at max hold.
        cnt_nx = h_eff - ONE;
        case (state)
          PH1:     state_nx = PH2;
          PH2:     state_nx = PH3;
          PH3:     state_nx = GAP;
          GAP: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end
          default: state_nx = IDLE;
        endcase
      end else begin
        cnt_nx = cnt - ONE;
      end
    end

    // Enter walks 10 -> 11 -> 01, exit walks 01 -> 11 -> 10; one bit per step.
    case (state_nx)
      PH1:     {outer_nx, inner_nx} = dir_nx ? 2'b01 : 2'b10;
      PH2:     {outer_nx, inner_nx} = 2'b11;
      PH3:     {outer_nx, inner_nx} = dir_nx ? 2'b10 : 2'b01;
      default: {outer_nx, inner_nx} = 2'b00;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_car_sensor_driver.sv
// tb_car_sensor_driver: directed and random requests against a cycle-level
// expectation queue built from the gate pattern tables, plus a small bench
// detector that decodes enters/exits from the observed sensor stream.
module tb_car_sensor_driver;

  localparam int HOLD_W = 8;

  logic              clk;
  logic              reset;
  logic              start_enter;
  logic              start_exit;
  logic [HOLD_W-1:0] hold;
  logic              outer;
  logic              inner;
  logic              busy;
  logic              done;
  logic              rejected;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected {outer, inner, busy, done} per cycle, one entry per cycle.
  logic [3:0] exp_q[$];
  logic [3:0] cur;
  logic       exp_rej;

  // Bench-side sensor-stream detector.
  logic [1:0] prev_s;
  logic [1:0] hist[3];
  int         det_enter;
  int         det_exit;

  // Gate patterns: phase 0..3 for enter and exit.
  logic [1:0] pat_enter[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] pat_exit[4]  = '{2'b01, 2'b11, 2'b10, 2'b00};

  car_sensor_driver #(.HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_enter (start_enter),
    .start_exit  (start_exit),
    .hold        (hold),
    .outer       (outer),
    .inner       (inner),
    .busy        (busy),
    .done        (done),
    .rejected    (rejected),
    .dbg_state   (dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    cur     = 4'b0000;
    exp_rej = 1'b0;
    prev_s  = 2'b00;
    for (int i = 0; i < 3; i++) hist[i] = 2'b00;
  endtask

  // One clock cycle: drive at negedge, model the edge, compare after it.
  task automatic cycle(input logic se, input logic sx, input logic [HOLD_W-1:0] h);
    logic       idle_now;
    logic       acc;
    int         he;
    logic [1:0] s;
    start_enter = se;
    start_exit  = sx;
    hold        = h;
    idle_now = !cur[1];
    acc      = idle_now && (se ^ sx);
    exp_rej  = (idle_now && se && sx) || (!idle_now && (se || sx));
    if (acc) begin
      he = (h == 0) ? 1 : int'(h);
      for (int p = 0; p < 4; p++)
        for (int c = 0; c < he; c++)
          exp_q.push_back({sx ? pat_exit[p] : pat_enter[p], 1'b1, 1'b0});
      exp_q.push_back(4'b0001);
    end
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    @(posedge clk);
    #1;
    chk("outer",    int'(outer),    int'(cur[3]));
    chk("inner",    int'(inner),    int'(cur[2]));
    chk("busy",     int'(busy),     int'(cur[1]));
    chk("done",     int'(done),     int'(cur[0]));
    chk("rejected", int'(rejected), int'(exp_rej));
    s = {outer, inner};
    if (s != prev_s) begin
      chk("one_bit_step", $countones(s ^ prev_s), 1);
      if (s == 2'b00) begin
        if (hist[2] == 2'b10 && hist[1] == 2'b11 && hist[0] == 2'b01) det_enter++;
        if (hist[2] == 2'b01 && hist[1] == 2'b11 && hist[0] == 2'b10) det_exit++;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s;
      prev_s  = s;
    end
    @(negedge clk);
    start_enter = 1'b0;
    start_exit  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, HOLD_W'($urandom_range(0, 255)));
  endtask

  // Directed steps followed by random traffic.
  initial begin
    int r;
    reset       = 1'b1;
    start_enter = 1'b0;
    start_exit  = 1'b0;
    hold        = '0;
    det_enter   = 0;
    det_exit    = 0;
    clear_model();
    #2;
    chk("rst_outer", int'(outer), 0);
    chk("rst_inner", int'(inner), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_rej",   int'(rejected), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Enter, hold = 3: 12 busy cycles then done.
    cycle(1'b1, 1'b0, 8'd3);
    idle(14);

    // Exit, hold = 0 behaves as 1.
    cycle(1'b0, 1'b1, 8'd0);
    idle(6);

    // Both starts in IDLE are refused.
    cycle(1'b1, 1'b1, 8'd4);
    idle(3);

    // Start while busy (enter PH2, hold = 4) is refused; enter completes.
    cycle(1'b1, 1'b0, 8'd4);
    idle(5);
    cycle(1'b0, 1'b1, 8'd7);
    idle(14);

    // Start held for several cycles: first accepted, rest refused.
    cycle(1'b0, 1'b1, 8'd2);
    cycle(1'b0, 1'b1, 8'd2);
    cycle(1'b0, 1'b1, 8'd2);
    idle(10);

    // Reset mid-sequence: enter hold = 5, reset in PH2 away from the edge.
    cycle(1'b1, 1'b0, 8'd5);
    idle(6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_outer", int'(outer), 0);
    chk("async_inner", int'(inner), 0);
    chk("async_busy",  int'(busy),  0);
    chk("async_done",  int'(done),  0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    cycle(1'b1, 1'b0, 8'd5);
    idle(22);

    // Back-to-back enters, second started in the done cycle of the first.
    det_enter = 0;
    det_exit  = 0;
    cycle(1'b1, 1'b0, 8'd2);
    idle(8);
    cycle(1'b1, 1'b0, 8'd2);
    idle(10);
    chk("det_enters", det_enter, 2);
    chk("det_exits",  det_exit,  0);

    // Maximum hold: exit with hold = 255, counter must not wrap.
    cycle(1'b0, 1'b1, 8'd255);
    idle(1025);

    // Random traffic; hold changes every cycle and must be ignored mid-run.
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 15));
      cycle(r == 0 || r == 2, r == 1 || r == 2, HOLD_W'($urandom_range(0, 6)));
    end
    idle(30);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
